// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : proc_run_ctrl
//  Purpose  : Run controller for an attached processor. Starts a run on
//             request, enables the processor until it halts or an optional
//             cycle limit expires, holds the enable low for a fixed drain
//             period, then reports completion with the captured cycle count,
//             run length and timeout status.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_run_ctrl #(
    parameter int CC_W         = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CC_W-1:0] timeout_limit,
    input  logic            halt,
    input  logic [CC_W-1:0] cc,
    output logic            en,
    output logic            busy,
    output logic            done,
    output logic            timed_out,
    output logic [CC_W-1:0] result_cc,
    output logic [CC_W-1:0] run_cycles
);

    // DRAIN_CYCLES is at most 15, so four bits always hold the drain count.
    localparam int DC_W = 4;

    localparam logic [DC_W-1:0] C_DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [DC_W-1:0] C_DC_ONE     = {{(DC_W-1){1'b0}}, 1'b1};
    localparam logic [CC_W-1:0] C_CC_MAX     = {CC_W{1'b1}};
    localparam logic [CC_W-1:0] C_CC_ONE     = {{(CC_W-1){1'b0}}, 1'b1};
    localparam logic [CC_W:0]   C_CCX_ONE    = {{CC_W{1'b0}}, 1'b1};

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_RUN   = 2'd1;
    localparam logic [1:0] C_DRAIN = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [DC_W-1:0] r_drain_cnt;

    logic            w_start_run;
    logic            w_timeout_hit;
    logic            w_run_exit;
    logic            w_drain_last;
    logic [CC_W:0]   w_run_plus1;

    logic            w_en_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    // The +1 is formed one bit wider so a saturated counter can never alias
    // back onto a small limit value.
    assign w_run_plus1   = {1'b0, run_cycles} + C_CCX_ONE;

    // Limit is compared live every cycle; halt takes priority over timeout.
    assign w_timeout_hit = (timeout_limit != '0)
                         && (w_run_plus1 == {1'b0, timeout_limit})
                         && !halt;

    // Start is honoured only when no run is in progress.
    assign w_start_run   = start && ((r_state == C_IDLE) || (r_state == C_DONE));

    assign w_run_exit    = (r_state == C_RUN) && (halt || w_timeout_hit);

    assign w_drain_last  = (r_drain_cnt == C_DRAIN_LAST);

    // State register plus registered copies of the state-decoded outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_IDLE;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            en      <= w_en_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_start_run) begin
                    w_state_nxt = C_RUN;
                end
            end
            C_RUN: begin
                if (w_run_exit) begin
                    w_state_nxt = C_DRAIN;
                end
            end
            C_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt = C_DONE;
                end
            end
            C_DONE: begin
                if (w_start_run) begin
                    w_state_nxt = C_RUN;
                end
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered versions
    // line up with the state they describe.
    always_comb begin
        w_en_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            C_RUN: begin
                w_en_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            C_DRAIN: begin
                w_busy_nxt = 1'b1;
            end
            C_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_en_nxt   = 1'b0;
            end
        endcase
    end

    // Run statistics: cleared on run entry, counted during RUN, captured on
    // the exit edge and held through DRAIN and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles <= '0;
            result_cc  <= '0;
            timed_out  <= 1'b0;
        end else if (w_start_run) begin
            run_cycles <= '0;
            result_cc  <= '0;
            timed_out  <= 1'b0;
        end else if (r_state == C_RUN) begin
            if (run_cycles != C_CC_MAX) begin
                run_cycles <= run_cycles + C_CC_ONE;
            end
            if (w_run_exit) begin
                result_cc <= cc;
                timed_out <= w_timeout_hit;
            end
        end
    end

    // Drain counter: zeroed as RUN exits, advanced each DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (w_run_exit) begin
            r_drain_cnt <= '0;
        end else if ((r_state == C_DRAIN) && !w_drain_last) begin
            r_drain_cnt <= r_drain_cnt + C_DC_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_run_ctrl
//  Purpose  : Self-checking bench for proc_run_ctrl. Each run pushes its
//             expected completion record; a monitor pops and compares it
//             when done rises. Scenario tasks add inline checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] timeout_limit;
    logic        halt;
    logic [15:0] cc;
    logic        en;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] result_cc;
    logic [15:0] run_cycles;

    typedef struct {
        logic [15:0] rcc;
        logic [15:0] rcyc;
        logic        tout;
        int          en_n;
        int          drn_n;
    } exp_t;

    exp_t sb[$];

    int vec;
    int mis;
    int en_cnt;
    int drn_cnt;
    int done_cyc;
    logic done_q;

    proc_run_ctrl #(
        .CC_W         (16),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .timeout_limit (timeout_limit),
        .halt          (halt),
        .cc            (cc),
        .en            (en),
        .busy          (busy),
        .done          (done),
        .timed_out     (timed_out),
        .result_cc     (result_cc),
        .run_cycles    (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts enable/drain/done cycles and checks each completion.
    always @(negedge clk) begin
        exp_t e;
        if (en) en_cnt++;
        if (busy && !en) drn_cnt++;
        if (done) done_cyc++;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                vec++; mis++;
                $display("FAIL sb_unexpected_done got done=1 want no completion pending");
            end else begin
                e = sb.pop_front();
                vec++;
                if (result_cc !== e.rcc) begin
                    mis++; $display("FAIL sb_result_cc got %h want %h", result_cc, e.rcc);
                end
                vec++;
                if (run_cycles !== e.rcyc) begin
                    mis++; $display("FAIL sb_run_cycles got %h want %h", run_cycles, e.rcyc);
                end
                vec++;
                if (timed_out !== e.tout) begin
                    mis++; $display("FAIL sb_timed_out got %b want %b", timed_out, e.tout);
                end
                vec++;
                if (en_cnt != e.en_n) begin
                    mis++; $display("FAIL sb_en_cycles got %0d want %0d", en_cnt, e.en_n);
                end
                vec++;
                if (drn_cnt != e.drn_n) begin
                    mis++; $display("FAIL sb_drain_cycles got %0d want %0d", drn_cnt, e.drn_n);
                end
                vec++;
                if (busy !== 1'b0) begin
                    mis++; $display("FAIL sb_busy_in_done got %b want 0", busy);
                end
            end
        end
        done_q = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        en_cnt  = 0;
        drn_cnt = 0;
    endtask

    task automatic push_exp(input logic [15:0] rcc, input logic [15:0] rcyc,
                            input logic tout, input int en_n);
        exp_t e;
        e.rcc = rcc; e.rcyc = rcyc; e.tout = tout; e.en_n = en_n; e.drn_n = 2;
        sb.push_back(e);
    endtask

    // Issues a one-cycle start; returns in the first RUN cycle.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then one more cycle so the monitor sees it.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        vec++;
        if (!seen) begin
            mis++; $display("FAIL %s_done_timeout got done=0 want done=1 within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vec++;
        if ({en, busy, done, timed_out} !== 4'b0000 || result_cc !== 16'h0 || run_cycles !== 16'h0) begin
            mis++;
            $display("FAIL reset_outputs got en=%b busy=%b done=%b to=%b rcc=%h rc=%h want all 0",
                     en, busy, done, timed_out, result_cc, run_cycles);
        end
        tick(); tick();
        rst = 1'b0;
        halt = 1'b1;
        repeat (5) tick();
        halt = 1'b0;
        vec++;
        if ({en, busy, done} !== 3'b000) begin
            mis++; $display("FAIL reset_idle_hold got en=%b busy=%b done=%b want 000", en, busy, done);
        end
    endtask

    task automatic test_normal_halt();
        timeout_limit = 16'd100;
        cc = 16'h000A;
        clear_counts();
        push_exp(16'h000A, 16'd10, 1'b0, 10);
        pulse_start();
        vec++;
        if (en !== 1'b1 || run_cycles !== 16'd0) begin
            mis++; $display("FAIL normal_entry got en=%b rc=%h want en=1 rc=0000", en, run_cycles);
        end
        repeat (9) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        vec++;
        if (en !== 1'b0 || busy !== 1'b1) begin
            mis++; $display("FAIL normal_drain got en=%b busy=%b want en=0 busy=1", en, busy);
        end
        wait_done("normal");
    endtask

    task automatic test_timeout();
        timeout_limit = 16'd5;
        cc = 16'h1234;
        clear_counts();
        push_exp(16'h1234, 16'd5, 1'b1, 5);
        pulse_start();
        wait_done("timeout");
    endtask

    task automatic test_tie();
        timeout_limit = 16'd8;
        cc = 16'h0808;
        clear_counts();
        push_exp(16'h0808, 16'd8, 1'b0, 8);
        pulse_start();
        repeat (7) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done("tie");
    endtask

    task automatic test_halt_on_entry();
        timeout_limit = 16'd100;
        cc = 16'h0001;
        clear_counts();
        push_exp(16'h0001, 16'd1, 1'b0, 1);
        halt = 1'b1;
        pulse_start();
        tick();
        halt = 1'b0;
        wait_done("halt_entry");
    endtask

    task automatic test_limit_change();
        timeout_limit = 16'd100;
        cc = 16'h0BEE;
        clear_counts();
        push_exp(16'h0BEE, 16'd12, 1'b1, 12);
        pulse_start();
        repeat (4) tick();
        timeout_limit = 16'd3;
        repeat (5) tick();
        vec++;
        if (en !== 1'b1 || run_cycles !== 16'd9) begin
            mis++; $display("FAIL limit_below got en=%b rc=%h want en=1 rc=0009", en, run_cycles);
        end
        timeout_limit = 16'd12;
        wait_done("limit_change");
    endtask

    task automatic test_restart_ignore();
        timeout_limit = 16'd4;
        cc = 16'h0C0C;
        clear_counts();
        push_exp(16'h0C0C, 16'd4, 1'b1, 4);
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vec++;
        if (done !== 1'b1 || en !== 1'b0) begin
            mis++; $display("FAIL ignore_start got done=%b en=%b want done=1 en=0", done, en);
        end
        tick();
        clear_counts();
        cc = 16'h0D0D;
        push_exp(16'h0D0D, 16'd3, 1'b0, 3);
        pulse_start();
        vec++;
        if ({en, busy, done, timed_out} !== 4'b1100 || run_cycles !== 16'h0 || result_cc !== 16'h0) begin
            mis++;
            $display("FAIL restart_entry got en=%b busy=%b done=%b to=%b rc=%h rcc=%h want 1 1 0 0 0000 0000",
                     en, busy, done, timed_out, run_cycles, result_cc);
        end
        tick(); tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done("restart");
    endtask

    task automatic test_async_reset();
        timeout_limit = 16'd100;
        cc = 16'h5555;
        clear_counts();
        pulse_start();
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        vec++;
        if ({en, busy, done, timed_out} !== 4'b0000 || result_cc !== 16'h0 || run_cycles !== 16'h0) begin
            mis++;
            $display("FAIL async_reset got en=%b busy=%b done=%b to=%b rcc=%h rc=%h want all 0",
                     en, busy, done, timed_out, result_cc, run_cycles);
        end
        #1;
        rst = 1'b0;
        done_cyc = 0;
        repeat (20) tick();
        vec++;
        if (done_cyc != 0 || busy !== 1'b0 || en !== 1'b0) begin
            mis++;
            $display("FAIL async_no_done got done_cycles=%0d busy=%b en=%b want 0 0 0", done_cyc, busy, en);
        end
    endtask

    task automatic test_saturation();
        timeout_limit = 16'd0;
        cc = 16'hFACE;
        clear_counts();
        push_exp(16'hFACE, 16'hFFFF, 1'b0, 70000);
        pulse_start();
        repeat (999) tick();
        vec++;
        if (run_cycles !== 16'd999) begin
            mis++; $display("FAIL sat_midway got %h want %h", run_cycles, 16'd999);
        end
        repeat (69000) tick();
        vec++;
        if (run_cycles !== 16'hFFFF || en !== 1'b1) begin
            mis++; $display("FAIL sat_hold got rc=%h en=%b want rc=ffff en=1", run_cycles, en);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done("saturation");
    endtask

    initial begin
        vec = 0; mis = 0;
        en_cnt = 0; drn_cnt = 0; done_cyc = 0; done_q = 1'b0;
        rst = 1'b0; start = 1'b0; halt = 1'b0;
        timeout_limit = 16'h0; cc = 16'h0;

        test_reset();
        test_normal_halt();
        test_timeout();
        test_tie();
        test_halt_on_entry();
        test_limit_change();
        test_restart_ignore();
        test_async_reset();
        test_saturation();

        vec++;
        if (sb.size() != 0) begin
            mis++; $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 Parameter CC_W, default 16: width of the processor cycle count and all counters.
REQ-002 Parameter DRAIN_CYCLES, default 2: cycles `en` is held low after a run ends, before `done` asserts; legal range 1..15.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 start  input  1: one-cycle run request.
REQ-006 timeout_limit  input  CC_W: maximum run length in cycles; 0 disables the timeout.
REQ-007 halt  input  1: halt flag from the processor.
REQ-008 cc  input  CC_W: processor cycle count.
REQ-009 en  output  1: processor enable.
REQ-010 busy  output  1: high in RUN and DRAIN.
REQ-011 done  output  1: high in DONE.
REQ-012 timed_out  output  1: the last run ended by timeout.
REQ-013 result_cc  output  CC_W: `cc` captured at the end of the run.
REQ-014 run_cycles  output  CC_W: number of cycles `en` was high in the current or last run.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE. All outputs SHALL be registered.
REQ-016 IDLE: `en`=0, `busy`=0, `done`=0. `halt` is ignored. A sampled `start`=1 moves to RUN on the next edge.
REQ-017 Entering RUN: `en`=1 from the first cycle; `run_cycles`, `result_cc` and `timed_out` are cleared on the same edge.
REQ-018 RUN: `run_cycles` increments by 1 on every edge while in RUN and saturates at all-ones; no wrap.
REQ-019 RUN with `halt`=1 sampled: next edge moves to DRAIN, `en`=0, `result_cc`<=`cc` sampled on that edge, `timed_out`=0.
REQ-020 Timeout condition: `timeout_limit`!=0 and (`run_cycles`+1)==`timeout_limit` with `halt`=0.
REQ-021 On the timeout condition, the next edge moves to DRAIN with `en`=0, `timed_out`=1 and `result_cc`<=`cc`. `en` is therefore high for exactly `timeout_limit` cycles.
REQ-022 `halt` and the timeout condition in the same cycle: `halt` wins and `timed_out`=0.
REQ-023 `timeout_limit` is sampled every cycle; a change mid-run takes effect immediately. A limit already below `run_cycles`+1 never fires.
REQ-024 DRAIN: `en`=0 for exactly DRAIN_CYCLES cycles, counted by an internal counter, then DONE.
REQ-025 `start` in RUN or DRAIN SHALL be ignored, not queued.
REQ-026 DONE: `done`=1 and `busy`=0. `result_cc`, `run_cycles` and `timed_out` hold until the next run starts.
REQ-027 `start` in DONE moves directly to RUN and follows REQ-017.
REQ-028 `halt`=1 already asserted on the RUN entry cycle: `en` is high for exactly 1 cycle and `run_cycles`=1.

Reset
REQ-029 `rst`=1 SHALL immediately, without waiting for `clk`, force state IDLE and drive `en`, `busy`, `done` and `timed_out` to 0, and `result_cc`, `run_cycles` and the drain counter to 0.
REQ-030 Reset asserted mid-RUN SHALL drop `en` asynchronously, with no DRAIN and no `done`.
REQ-031 After `rst` deasserts, the block stays in IDLE until a `start` is sampled.

Verification
REQ-032 Normal halt: `timeout_limit`=100, `start` pulse, `halt` rises after `en` has been high 10 cycles with `cc`=0x000A -> `en` high exactly 10 cycles, then `busy`=1 for 2 cycles, then `done`=1, `result_cc`=0x000A, `run_cycles`=10, `timed_out`=0.
REQ-033 Timeout: `timeout_limit`=5, `halt` held 0 -> `en` high exactly 5 cycles, `timed_out`=1, `run_cycles`=5, `done`=1 after 2 drain cycles.
REQ-034 Tie: `timeout_limit`=8, `halt`=1 on the cycle `run_cycles`=7 -> `timed_out`=0, `run_cycles`=8.
REQ-035 Async reset: `rst` pulsed between clock edges at run cycle 4 -> `en`=0 before the next edge, all outputs 0, no `done` ever asserted.
REQ-036 Restart and ignore: `start` pulses during RUN and DRAIN -> no effect. `start` in DONE -> RUN next edge, `run_cycles`=0 and `timed_out` cleared on entry.
REQ-037 Saturation: `timeout_limit`=0, `halt` held 0 for 70000 cycles -> `run_cycles`=0xFFFF held with no wrap, `en` stays high.
